// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared states, opcode constants and BCD helpers for bcd_serial_alu
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    NEG,
    DONE
  } alu_state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b010;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Nines complement of one BCD digit; only meaningful for digits 0..9
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return BCD_MAX_DIGIT - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single BCD digit adder with carry
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] bin_sum;

  // Binary sum then decimal correction: anything above 9 wraps by adding 6
  always_comb begin
    bin_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (bin_sum > 5'd9) begin
      sum  = bin_sum[3:0] + 4'd6;
      cout = 1'b1;
    end else begin
      sum  = bin_sum[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_alu.sv
// rtl/bcd_serial_alu.sv - digit-serial BCD add/subtract unit with sign-magnitude result
module bcd_serial_alu
  import alu_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   op1,
  input  logic [4*DIGITS-1:0]   op2,
  input  logic [2:0]            opcode,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry_out,
  output logic                  negative,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  alu_state_t state, state_next;

  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          sub_reg;
  logic          carry;
  logic [IW-1:0] idx;

  logic          sub_sel;
  logic          bad_digit;
  logic          last_digit;
  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [3:0]    r_dig;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic [3:0]    add_sum;
  logic          add_cout;

  assign sub_sel    = (opcode & OP_SUB) == OP_SUB;
  assign last_digit = (idx == LAST_IDX);
  assign busy       = (state == ADD) || (state == NEG);
  assign done       = (state == DONE);

  // Flag any non-BCD digit in either operand presented at start
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (op1[4*i +: 4] > BCD_MAX_DIGIT || op2[4*i +: 4] > BCD_MAX_DIGIT) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Operand muxes for the shared digit adder: A+B' in ADD, 0+(9-r) in NEG
  always_comb begin
    a_dig = a_reg[{idx, 2'b00} +: 4];
    b_dig = b_reg[{idx, 2'b00} +: 4];
    r_dig = result[{idx, 2'b00} +: 4];
    if (state == NEG) begin
      add_a = 4'd0;
      add_b = nines_comp(r_dig);
    end else begin
      add_a = a_dig;
      add_b = sub_reg ? nines_comp(b_dig) : b_dig;
    end
  end

  bcd_digit_add u_digit_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: a missing final carry on subtract means a borrow, so recomplement
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = bad_digit ? DONE : ADD;
      ADD:  if (last_digit) state_next = (sub_reg && !add_cout) ? NEG : DONE;
      NEG:  if (last_digit) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, per-digit result writes, carry and flag updates
  always_ff @(posedge clk) begin
    if (!nrst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      negative  <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= op1;
            b_reg     <= op2;
            sub_reg   <= sub_sel;
            carry     <= sub_sel;
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            negative  <= 1'b0;
            invalid   <= bad_digit;
          end
        end
        ADD: begin
          result[{idx, 2'b00} +: 4] <= add_sum;
          if (last_digit) begin
            idx <= '0;
            if (!sub_reg) begin
              carry     <= add_cout;
              carry_out <= add_cout;
            end else if (!add_cout) begin
              negative <= 1'b1;
              carry    <= 1'b1;
            end else begin
              carry <= add_cout;
            end
          end else begin
            idx   <= idx + 1'b1;
            carry <= add_cout;
          end
        end
        NEG: begin
          result[{idx, 2'b00} +: 4] <= add_sum;
          carry <= add_cout;
          idx   <= last_digit ? '0 : idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
